// File: rtl/song_if.sv
// Control and playback-status bundle between a melody player and its controller.
// Master drives start/stop/loop_en; slave (the player) drives the note and status outputs.
interface song_if #(
  parameter int NOTE_W = 16,
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [NOTE_W-1:0] note;
  logic              playing;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] index;

  modport master (
    output start, stop, loop_en,
    input  note, playing, busy, done, index
  );

  modport slave (
    input  start, stop, loop_en,
    output note, playing, busy, done, index
  );
endinterface

// File: rtl/song_sequencer.sv
// Self-timed melody player: walks an internal {dur, period} table, holding each note
// for dur*UNIT_CYC clocks followed by GAP_CYC silent clocks; note valid two clocks after start.
module song_sequencer #(
  parameter int NOTE_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int DUR_W    = 3,
  parameter int UNIT_CYC = 12500000,
  parameter int GAP_CYC  = 1250000,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic reset,
  song_if.slave sif
);

  localparam int ENT_W = DUR_W + NOTE_W;

  localparam logic [NOTE_W-1:0] P_C  = NOTE_W'(45866);
  localparam logic [NOTE_W-1:0] P_D  = NOTE_W'(40863);
  localparam logic [NOTE_W-1:0] P_E  = NOTE_W'(36404);
  localparam logic [NOTE_W-1:0] P_F  = NOTE_W'(34361);
  localparam logic [NOTE_W-1:0] P_G  = NOTE_W'(30612);
  localparam logic [NOTE_W-1:0] P_A  = NOTE_W'(27272);
  localparam logic [NOTE_W-1:0] P_AS = NOTE_W'(25742);
  localparam logic [NOTE_W-1:0] P_C5 = NOTE_W'(22933);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, GAP} state_t;

  state_t            state;
  logic [ENT_W-1:0]  rom_dat;
  logic [NOTE_W-1:0] rom_period;
  logic [DUR_W-1:0]  rom_dur;
  logic [CNT_W-1:0]  cnt;
  logic              wrapped;
  logic              end_of_song;
  logic [NOTE_W-1:0] note_q;
  logic              playing_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] idx_q;

  function automatic logic [ENT_W-1:0] song_entry(input logic [ADDR_W-1:0] a);
    logic [NOTE_W-1:0] p;
    logic [DUR_W-1:0]  d;
    p = '0;
    d = DUR_W'(1);
    case (int'(a))
      0, 1, 3, 6, 7, 9, 10, 13, 14: p = P_C;
      2, 8, 19:                     p = P_D;
      5, 18:                        p = P_E;
      4, 12, 17, 23, 25:            p = P_F;
      11, 24:                       p = P_G;
      16, 22:                       p = P_A;
      20, 21:                       p = P_AS;
      15:                           p = P_C5;
      default: begin
        p = '0;
        d = '0;
      end
    endcase
    case (int'(a))
      5, 12, 19, 25: d = DUR_W'(2);
      default:       ;
    endcase
    return {d, p};
  endfunction

  // Synchronous table read: data for idx_q is available one clock later (in DECODE).
  always_ff @(posedge clk) begin
    rom_dat <= song_entry(idx_q);
  end

  assign rom_period  = rom_dat[NOTE_W-1:0];
  assign rom_dur     = rom_dat[ENT_W-1:NOTE_W];
  assign end_of_song = (rom_period == '0) || (rom_dur == '0) || wrapped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      note_q    <= '0;
      playing_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      cnt       <= '0;
      wrapped   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && sif.stop) begin
        state     <= IDLE;
        note_q    <= '0;
        playing_q <= 1'b0;
        busy_q    <= 1'b0;
        idx_q     <= '0;
        cnt       <= '0;
        wrapped   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sif.start && !sif.stop) begin
              state   <= FETCH;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              wrapped <= 1'b0;
            end
          end
          FETCH: state <= DECODE;
          DECODE: begin
            if (!end_of_song) begin
              note_q    <= rom_period;
              playing_q <= 1'b1;
              cnt       <= CNT_W'(rom_dur) * CNT_W'(UNIT_CYC) - CNT_W'(1);
              state     <= PLAY;
            end else if (sif.loop_en) begin
              idx_q   <= '0;
              wrapped <= 1'b0;
              state   <= FETCH;
            end else begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
          PLAY: begin
            if (cnt == '0) begin
              note_q    <= '0;
              playing_q <= 1'b0;
              if (GAP_CYC == 0) begin
                idx_q <= idx_q + ADDR_W'(1);
                if (idx_q == '1) wrapped <= 1'b1;
                state <= FETCH;
              end else begin
                cnt   <= CNT_W'(GAP_CYC - 1);
                state <= GAP;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt == '0) begin
              // Advancing past the last address marks the song as finished.
              idx_q <= idx_q + ADDR_W'(1);
              if (idx_q == '1) wrapped <= 1'b1;
              state <= FETCH;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign sif.note    = note_q;
  assign sif.playing = playing_q;
  assign sif.busy    = busy_q;
  assign sif.done    = done_q;
  assign sif.index   = idx_q;

endmodule
